// File: rtl/decoder_onehot_seq.sv
// rtl/decoder_onehot_seq.sv - registered binary-to-one-hot decoder with level/pulse/scan/sticky modes
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   en              block enable; low forces idle with out cleared
//   mode            00 level, 01 pulse, 10 scan, 11 sticky
//   in, in_valid    binary index and its valid qualifier
//   in_ready        combinational accept indication
//   hold            extra cycles per pulse or scan slot
//   clr             clears the accumulated output in sticky mode
//   out, idx        registered decoded output and the index it represents
//   busy            high while a pulse or scan sequence runs
module decoder_onehot_seq #(
  parameter  int SEL_W  = 3,
  parameter  int HOLD_W = 4,
  localparam int OUT_W  = 1 << SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [SEL_W-1:0]  in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HOLD_W-1:0] hold,
  input  logic              clr,
  output logic [OUT_W-1:0]  out,
  output logic [SEL_W-1:0]  idx,
  output logic              busy
);

  localparam logic [1:0] M_LEVEL  = 2'b00;
  localparam logic [1:0] M_PULSE  = 2'b01;
  localparam logic [1:0] M_SCAN   = 2'b10;
  localparam logic [1:0] M_STICKY = 2'b11;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [1:0]         mode_q;
  logic [HOLD_W-1:0]  cnt, cnt_n;
  logic [OUT_W-1:0]   out_n;
  logic [SEL_W-1:0]   idx_n;
  logic               busy_n;

  logic               mode_ok;
  logic               accept;
  logic [SEL_W-1:0]   idx_inc;
  logic [OUT_W-1:0]   dec_in;
  logic [OUT_W-1:0]   dec_inc;

  // Decoders for the incoming index and for the next scan slot.
  // The index increment wraps naturally at OUT_W-1 because idx is SEL_W bits.
  always_comb begin
    idx_inc = idx + SEL_W'(1);
    dec_in = '0;
    dec_in[in] = 1'b1;
    dec_inc = '0;
    dec_inc[idx_inc] = 1'b1;
  end

  // A mode switch spends one cycle with the input blocked while the
  // block drops back to idle, so no transfer is split across two modes.
  assign mode_ok = (mode == mode_q);

  always_comb begin
    in_ready = 1'b0;
    if (en && mode_ok) begin
      if (mode == M_PULSE) begin
        in_ready = (state == IDLE);
      end else begin
        in_ready = 1'b1;
      end
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_n = state;
    out_n   = out;
    idx_n   = idx;
    cnt_n   = cnt;
    busy_n  = busy;

    if (!en || !mode_ok) begin
      // idx is deliberately retained so software can still see the last index.
      state_n = IDLE;
      out_n   = '0;
      busy_n  = 1'b0;
      cnt_n   = '0;
    end else begin
      case (mode)
        M_LEVEL: begin
          state_n = IDLE;
          busy_n  = 1'b0;
          if (accept) begin
            out_n = dec_in;
            idx_n = in;
          end
        end

        M_PULSE: begin
          if (state == IDLE) begin
            if (accept) begin
              out_n   = dec_in;
              idx_n   = in;
              cnt_n   = hold;
              busy_n  = 1'b1;
              state_n = ACTIVE;
            end
          end else if (cnt != '0) begin
            cnt_n = cnt - HOLD_W'(1);
          end else begin
            out_n   = '0;
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end

        M_SCAN: begin
          // An accept always wins, so a new seed restarts the slot even
          // when the current slot was about to advance.
          if (accept) begin
            out_n   = dec_in;
            idx_n   = in;
            cnt_n   = hold;
            busy_n  = 1'b1;
            state_n = ACTIVE;
          end else if (state == ACTIVE) begin
            if (cnt == '0) begin
              idx_n = idx_inc;
              out_n = dec_inc;
              cnt_n = hold;
            end else begin
              cnt_n = cnt - HOLD_W'(1);
            end
          end
        end

        M_STICKY: begin
          state_n = IDLE;
          busy_n  = 1'b0;
          if (accept) begin
            // Clear is applied before the set when both arrive together.
            out_n = clr ? dec_in : (out | dec_in);
            idx_n = in;
          end else if (clr) begin
            out_n = '0;
          end
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mode_q <= M_LEVEL;
      cnt    <= '0;
      out    <= '0;
      idx    <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      mode_q <= mode;
      cnt    <= cnt_n;
      out    <= out_n;
      idx    <= idx_n;
      busy   <= busy_n;
    end
  end

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// tb/tb_decoder_onehot_seq.sv - self-checking bench for decoder_onehot_seq at SEL_W=2,3,4
module tb_decoder_onehot_seq;

  logic        clk;
  logic        rst, en, valid, clr;
  logic [1:0]  mode;
  logic [3:0]  tin, hold;

  logic [3:0]  o2;
  logic [7:0]  o3;
  logic [15:0] o4;
  logic [1:0]  idx2;
  logic [2:0]  idx3;
  logic [3:0]  idx4;
  logic        b2, b3, b4, r2, r3, r4;

  int total = 0;
  int bad   = 0;

  decoder_onehot_seq #(.SEL_W(2), .HOLD_W(4)) d2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(tin[1:0]), .in_valid(valid),
    .in_ready(r2), .hold(hold), .clr(clr), .out(o2), .idx(idx2), .busy(b2));

  decoder_onehot_seq #(.SEL_W(3), .HOLD_W(4)) d3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(tin[2:0]), .in_valid(valid),
    .in_ready(r3), .hold(hold), .clr(clr), .out(o3), .idx(idx3), .busy(b3));

  decoder_onehot_seq #(.SEL_W(4), .HOLD_W(4)) d4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(tin), .in_valid(valid),
    .in_ready(r4), .hold(hold), .clr(clr), .out(o4), .idx(idx4), .busy(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, one slot per instance (0: 4 outputs, 1: 8, 2: 16).
  // left = cycles the current pulse or scan slot still has to show.
  logic [15:0] m_out [3];
  int          m_idx [3];
  bit          m_act [3];
  int          m_left[3];
  logic [1:0]  m_mq  [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_out[i] = '0; m_idx[i] = 0; m_act[i] = 0; m_left[i] = 0; m_mq[i] = 2'd0;
    end
  end

  function automatic bit model_ready(input int i);
    return en && (mode == m_mq[i]) && !(mode == 2'd1 && m_act[i]);
  endfunction

  task automatic model_step(input int i);
    int ow, ti;
    bit acc;
    ow  = 1 << (i + 2);
    ti  = int'(tin) % ow;
    acc = valid && model_ready(i);
    if (rst) begin
      m_out[i] = '0; m_idx[i] = 0; m_act[i] = 0; m_left[i] = 0; m_mq[i] = 2'd0;
      return;
    end
    if (!en || mode != m_mq[i]) begin
      m_out[i] = '0; m_act[i] = 0; m_left[i] = 0;
    end else begin
      case (mode)
        2'd0: if (acc) begin m_out[i] = 16'(1) << ti; m_idx[i] = ti; end
        2'd1: begin
          if (!m_act[i]) begin
            if (acc) begin
              m_out[i] = 16'(1) << ti; m_idx[i] = ti;
              m_left[i] = int'(hold) + 1; m_act[i] = 1;
            end
          end else begin
            m_left[i]--;
            if (m_left[i] == 0) begin m_out[i] = '0; m_act[i] = 0; end
          end
        end
        2'd2: begin
          if (acc) begin
            m_out[i] = 16'(1) << ti; m_idx[i] = ti;
            m_left[i] = int'(hold) + 1; m_act[i] = 1;
          end else if (m_act[i]) begin
            m_left[i]--;
            if (m_left[i] == 0) begin
              m_idx[i]  = (m_idx[i] + 1) % ow;
              m_out[i]  = 16'(1) << m_idx[i];
              m_left[i] = int'(hold) + 1;
            end
          end
        end
        default: begin
          if (acc) begin
            m_out[i] = (clr ? 16'h0 : m_out[i]) | (16'(1) << ti);
            m_idx[i] = ti;
          end else if (clr) begin
            m_out[i] = '0;
          end
        end
      endcase
    end
    m_mq[i] = mode;
  endtask

  task automatic cmp(input int i, input string tag, input logic [15:0] o,
                     input int ix, input logic b, input logic r);
    check({tag, "_out"},   32'(o), 32'(m_out[i]));
    check({tag, "_idx"},   32'(ix), 32'(m_idx[i]));
    check({tag, "_busy"},  32'(b), 32'(m_act[i]));
    check({tag, "_ready"}, 32'(r), 32'(model_ready(i)));
    if (m_mq[i] != 2'd3)
      check({tag, "_onehot"}, 32'($countones(o) <= 1), 32'd1);
  endtask

  always @(negedge clk) begin
    cmp(0, "s2", {12'b0, o2}, int'(idx2), b2, r2);
    cmp(1, "s3", {8'b0, o3},  int'(idx3), b3, r3);
    cmp(2, "s4", o4,          int'(idx4), b4, r4);
    for (int i = 0; i < 3; i++) model_step(i);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int scan_seq[8] = '{6, 6, 7, 7, 0, 0, 1, 1};

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; valid = 1'b0; hold = 4'd0; clr = 1'b0; tin = 4'd0;
    tick; tick;
    check("rst_out", 32'(o3), 32'h0);
    check("rst_idx", 32'(idx3), 32'h0);
    check("rst_busy", 32'(b3), 32'h0);

    // LEVEL
    rst = 1'b0; en = 1'b1; mode = 2'd0; tin = 4'd5; valid = 1'b1;
    #1 check("lvl_ready", 32'(r3), 32'h1);
    tick; valid = 1'b0;
    check("lvl_out", 32'(o3), 32'h20);
    check("lvl_idx", 32'(idx3), 32'h5);
    tick; tick;
    check("lvl_hold", 32'(o3), 32'h20);
    en = 1'b0;
    tick;
    check("en_off_out", 32'(o3), 32'h0);
    check("en_off_idx", 32'(idx3), 32'h5);

    // PULSE, hold=3, with in_valid kept high during the pulse
    en = 1'b1; mode = 2'd1;
    #1 check("modechg_ready", 32'(r3), 32'h0);
    tick;
    hold = 4'd3; tin = 4'd2; valid = 1'b1;
    #1 check("pls_ready_idle", 32'(r3), 32'h1);
    tick; tin = 4'd6;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("pls_out", 32'(o3), 32'h04);
      check("pls_busy", 32'(b3), 32'h1);
      check("pls_ready_act", 32'(r3), 32'h0);
      tick;
    end
    check("pls_end_out", 32'(o3), 32'h0);
    check("pls_end_busy", 32'(b3), 32'h0);
    hold = 4'd0;
    #1 check("pls_reaccept_ready", 32'(r3), 32'h1);
    tick; valid = 1'b0;
    check("pls1_out", 32'(o3), 32'h40);
    check("pls1_busy", 32'(b3), 32'h1);
    tick;
    check("pls1_end", 32'(o3), 32'h0);

    // mode change during an active pulse
    hold = 4'd5; tin = 4'd1; valid = 1'b1;
    tick; valid = 1'b0;
    tick;
    mode = 2'd0;
    #1 check("pls_modechg_ready", 32'(r3), 32'h0);
    tick;
    check("pls_modechg_out", 32'(o3), 32'h0);
    check("pls_modechg_busy", 32'(b3), 32'h0);

    // SCAN with wrap and re-seed
    mode = 2'd2;
    tick;
    hold = 4'd1; tin = 4'd6; valid = 1'b1;
    tick; valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("scan_idx", 32'(idx3), 32'(scan_seq[k]));
      check("scan_out", 32'(o3), 32'(1) << scan_seq[k]);
      tick;
    end
    tin = 4'd3; valid = 1'b1;
    tick; valid = 1'b0;
    check("reseed_idx", 32'(idx3), 32'h3);
    check("reseed_out", 32'(o3), 32'h08);
    tick;
    check("reseed_slot", 32'(idx3), 32'h3);
    tick;
    check("reseed_next", 32'(idx3), 32'h4);
    rst = 1'b1;
    tick; rst = 1'b0;
    check("midrst_out", 32'(o3), 32'h0);
    check("midrst_idx", 32'(idx3), 32'h0);
    check("midrst_busy", 32'(b3), 32'h0);

    // STICKY
    mode = 2'd3;
    tick;
    valid = 1'b1;
    tin = 4'd1; tick;
    tin = 4'd4; tick;
    tick;
    tin = 4'd7; tick;
    valid = 1'b0;
    check("sticky_acc", 32'(o3), 32'h92);
    clr = 1'b1; tin = 4'd0; valid = 1'b1;
    tick; valid = 1'b0;
    check("sticky_clrset", 32'(o3), 32'h01);
    tick; clr = 1'b0;
    check("sticky_clr", 32'(o3), 32'h0);

    // random sweep, all three widths checked against the model
    for (int n = 0; n < 2000; n++) begin
      rst   = ($urandom_range(0, 199) == 0);
      en    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      valid = 1'($urandom_range(0, 1));
      tin   = 4'($urandom);
      hold  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      clr   = ($urandom_range(0, 7) == 0);
      tick;
    end
    rst = 1'b0; valid = 1'b0; clr = 1'b0;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
